hier_serial_rx: RTL

//   Bit-serial frame receiver. It is the receive-side counterpart of the flop-driven serial net

---
 rtl/hier_serial_pkg.sv | 18 +
 rtl/hier_serial_rx_fifo.sv | 55 +++++
 rtl/hier_serial_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hier_serial_pkg.sv
// Shared types and helpers for the hier_serial_rx receiver.
package hier_serial_pkg;

    // Receiver FSM states; PARITY is only reachable when the parity option is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hier_serial_rx_fifo.sv
// Two-entry output buffer for hier_serial_rx.
// Handshake: a word leaves when pop is high and the buffer is not empty; a push is
// taken when the buffer is not full, or when it is full and a pop happens in the same
// cycle. The head entry (rdata) never changes while it is not being popped.
module hier_serial_rx_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; a full buffer with a pop reuses the freed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hier_serial_rx.sv
// Bit-serial frame receiver: start(0), DATA_W data bits LSB first, optional even
// parity, stop(1). Each bit lasts BIT_CYCLES clocks; the line is sampled when the
// cycle counter equals SAMPLE_PT. Build option: HIER_SERIAL_RX_PARITY_EN adds the
// PARITY state. dbg_state mirrors the FSM state for observation.
module hier_serial_rx
    import hier_serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int SAMPLE_PT  = 2
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_err,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    localparam int CW = cnt_w(BIT_CYCLES);
    localparam int IW = cnt_w(DATA_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SMP  = CW'(SAMPLE_PT);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    rx_state_e         state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic              sample_now;
    logic              bit_end;
    logic              par_bad;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

`ifdef HIER_SERIAL_RX_PARITY_EN
    logic              par_err;
    assign par_bad = par_err;
`else
    assign par_bad = 1'b0;
`endif

    assign sample_now = (cnt == CNT_SMP);
    assign bit_end    = (cnt == CNT_LAST);
    assign pop        = out_ready && !fifo_empty;
    // A good frame is pushed at the stop sample if there is room (or room is being made).
    assign push       = (state == STOP) && sample_now && in && !par_bad && (!fifo_full || pop);
    assign out_valid  = !fifo_empty;
    assign dbg_state  = state;

    // Framing FSM with cycle counter, bit index, shift register and registered error pulses.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef HIER_SERIAL_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!in) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (sample_now && in) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (bit_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= DATA;
`ifdef HIER_SERIAL_RX_PARITY_EN
                        par_err <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sample_now) begin
                        shreg <= {in, shreg[DATA_W-1:1]};
                    end
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
`ifdef HIER_SERIAL_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef HIER_SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (sample_now) begin
                        par_err <= (in != ^shreg);
                    end
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (sample_now) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!in || par_bad) begin
                            frame_err <= 1'b1;
                        end else if (!push) begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    hier_serial_rx_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (CK),
        .rst_n (RN),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
